// File: rtl/updown_modn_counter.sv
// Synchronous up/down modulo-N counter with parallel load.
// Carry/borrow pulses allow cascading digits; wrap or saturate at range ends.
module updown_modn_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             borrow,
    output logic             load_err,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH:0] MAX_V = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE   = (WIDTH+1)'(1);

    // One spare bit so MODULUS == 2**WIDTH compares cleanly.
    logic [WIDTH:0] q_r;
    logic [WIDTH:0] q_nxt;
    logic [WIDTH:0] lv_ext;
    logic           carry_nxt;
    logic           borrow_nxt;
    logic           load_err_nxt;

    assign lv_ext  = {1'b0, load_val};
    assign q       = q_r[WIDTH-1:0];
    assign at_max  = (q_r == MAX_V);
    assign at_zero = (q_r == '0);

    always_comb begin
        q_nxt        = q_r;
        carry_nxt    = 1'b0;
        borrow_nxt   = 1'b0;
        load_err_nxt = 1'b0;
        if (load) begin
            if (lv_ext <= MAX_V) begin
                q_nxt = lv_ext;
            end else begin
                q_nxt        = MAX_V;
                load_err_nxt = 1'b1;
            end
        end else if (en) begin
            unique case ({inc, dec})
                2'b10: begin
                    if (q_r == MAX_V) begin
                        carry_nxt = 1'b1;
                        if (SATURATE == 0) q_nxt = '0;
                    end else begin
                        q_nxt = q_r + ONE;
                    end
                end
                2'b01: begin
                    if (q_r == '0) begin
                        borrow_nxt = 1'b1;
                        if (SATURATE == 0) q_nxt = MAX_V;
                    end else begin
                        q_nxt = q_r - ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_r      <= '0;
            carry    <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
        end else begin
            q_r      <= q_nxt;
            carry    <= carry_nxt;
            borrow   <= borrow_nxt;
            load_err <= load_err_nxt;
        end
    end

endmodule
